// File: rtl/id_issue_latch.sv
// id_issue_latch: ID->EXE pipeline register with a configurable-depth drain sequencer for serialising instructions.
// Define ID_ISSUE_PERFCNT_EN to add the perf_bubbles/perf_serial saturating counters.
module id_issue_latch #(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 6,
    parameter int DRAIN_DEPTH = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_opa,
    input  logic [DATA_W-1:0] in_opb,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [4:0]        in_rega,
    input  logic [4:0]        in_regb,
    input  logic [4:0]        in_wreg,
    input  logic              in_regwrite,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [4:0]        in_shamt,
    input  logic              in_serial,
    input  logic              in_notify,
    input  logic              fwd_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb,
    output logic [DATA_W-1:0] out_memdata,
    output logic [4:0]        out_rega,
    output logic [4:0]        out_regb,
    output logic [4:0]        out_wreg,
    output logic              out_regwrite,
    output logic              out_memread,
    output logic              out_memwrite,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_shamt,
    output logic              sys_pulse,
    output logic              want_freeze,
`ifdef ID_ISSUE_PERFCNT_EN
    output logic [31:0]       perf_bubbles,
    output logic [15:0]       perf_serial,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_NOTIFY} state_t;

    state_t     r_state, w_next;
    logic [2:0] r_cnt, w_cnt_next;
    logic       r_notify, w_notify_next;
    logic       w_bubble, w_serial_pass, w_sys_next, w_keep;

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_notify_next = r_notify;
        w_bubble      = 1'b1;
        w_serial_pass = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && !fwd_stall) begin
                    w_bubble = 1'b0;
                    if (in_serial) begin
                        w_serial_pass = 1'b1;
                        w_notify_next = in_notify;
                        w_cnt_next    = 3'(DRAIN_DEPTH - 1);
                        w_next        = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    w_next        = S_IDLE;
                    w_cnt_next    = 3'd0;
                    w_notify_next = 1'b0;
                end else if (r_cnt == 3'd0) begin
                    w_next = S_NOTIFY;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_next        = S_IDLE;
                w_notify_next = 1'b0;
            end
        endcase
    end

    // A flush arriving in NOTIFY cancels the syscall request as well.
    assign w_sys_next  = (r_state == S_NOTIFY) && r_notify && !flush;
    assign w_keep      = !w_bubble && !w_serial_pass;
    assign want_freeze = (fwd_stall || (in_serial && r_state == S_IDLE) || r_state == S_DRAIN)
                         && r_state != S_NOTIFY;
    assign busy        = r_state != S_IDLE;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_notify     <= 1'b0;
            sys_pulse    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_opa      <= '0;
            out_opb      <= '0;
            out_memdata  <= '0;
            out_rega     <= '0;
            out_regb     <= '0;
            out_wreg     <= '0;
            out_regwrite <= 1'b0;
            out_memread  <= 1'b0;
            out_memwrite <= 1'b0;
            out_ctrl     <= '0;
            out_shamt    <= '0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_notify     <= w_notify_next;
            sys_pulse    <= w_sys_next;
            if (!w_bubble)
                out_pc <= in_pc;
            out_instr    <= w_bubble ? '0 : in_instr;
            out_opa      <= w_bubble ? '0 : in_opa;
            out_opb      <= w_bubble ? '0 : in_opb;
            out_memdata  <= w_bubble ? '0 : in_memdata;
            out_rega     <= w_bubble ? '0 : in_rega;
            out_regb     <= w_bubble ? '0 : in_regb;
            out_wreg     <= w_bubble ? '0 : in_wreg;
            out_ctrl     <= w_bubble ? '0 : in_ctrl;
            out_shamt    <= w_bubble ? '0 : in_shamt;
            out_regwrite <= w_keep && in_regwrite && in_wreg != 5'd0;
            out_memread  <= w_keep && in_memread;
            out_memwrite <= w_keep && in_memwrite;
        end
    end

`ifdef ID_ISSUE_PERFCNT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_bubbles <= '0;
            perf_serial  <= '0;
        end else begin
            if (w_bubble && perf_bubbles != '1)
                perf_bubbles <= perf_bubbles + 32'd1;
            if (w_serial_pass && perf_serial != '1)
                perf_serial <= perf_serial + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_issue_latch.sv
// tb_id_issue_latch: directed scoreboard bench for id_issue_latch (DRAIN_DEPTH=3).
// Honours ID_ISSUE_PERFCNT_EN when the design is built with it.
module tb_id_issue_latch;

    localparam int K_PASS = 0, K_BUB = 1, K_SER = 2;

    logic        CLK = 1'b0, RESET = 1'b1;
    logic [31:0] in_instr = '0, in_pc = '0, in_opa = '0, in_opb = '0, in_memdata = '0;
    logic [4:0]  in_rega = '0, in_regb = '0, in_wreg = '0, in_shamt = '0;
    logic        in_regwrite = 1'b0, in_memread = 1'b0, in_memwrite = 1'b0;
    logic [5:0]  in_ctrl = '0;
    logic        in_serial = 1'b0, in_notify = 1'b0, fwd_stall = 1'b0, flush = 1'b0;
    logic [31:0] out_instr, out_pc, out_opa, out_opb, out_memdata;
    logic [4:0]  out_rega, out_regb, out_wreg, out_shamt;
    logic        out_regwrite, out_memread, out_memwrite;
    logic [5:0]  out_ctrl;
    logic        sys_pulse, want_freeze, busy;
`ifdef ID_ISSUE_PERFCNT_EN
    logic [31:0] perf_bubbles;
    logic [15:0] perf_serial;
`endif

    id_issue_latch dut (
        .CLK(CLK), .RESET(RESET),
        .in_instr(in_instr), .in_pc(in_pc), .in_opa(in_opa), .in_opb(in_opb),
        .in_memdata(in_memdata), .in_rega(in_rega), .in_regb(in_regb), .in_wreg(in_wreg),
        .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_ctrl(in_ctrl), .in_shamt(in_shamt), .in_serial(in_serial), .in_notify(in_notify),
        .fwd_stall(fwd_stall), .flush(flush),
        .out_instr(out_instr), .out_pc(out_pc), .out_opa(out_opa), .out_opb(out_opb),
        .out_memdata(out_memdata), .out_rega(out_rega), .out_regb(out_regb), .out_wreg(out_wreg),
        .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
        .out_ctrl(out_ctrl), .out_shamt(out_shamt), .sys_pulse(sys_pulse),
        .want_freeze(want_freeze),
`ifdef ID_ISSUE_PERFCNT_EN
        .perf_bubbles(perf_bubbles), .perf_serial(perf_serial),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr, pc, opa, memdata;
        logic [4:0]  wreg;
        logic        rw, mr, mw, sp, busy;
        logic [5:0]  ctrl;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    int          m_bub = 0, m_ser = 0;
    logic [31:0] exp_pc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".instr"}, out_instr, 32'd0);
        chk({tag, ".pc"}, out_pc, 32'd0);
        chk({tag, ".rw"}, out_regwrite, 32'd0);
        chk({tag, ".ctrl"}, out_ctrl, 32'd0);
        chk({tag, ".sp"}, sys_pulse, 32'd0);
        chk({tag, ".busy"}, busy, 32'd0);
    endtask

    // Drive one ID slot, check want_freeze before the edge, then the latched result after it.
    task automatic cyc(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ser, input logic nt, input logic st, input logic fl,
                       input logic rw, input logic [4:0] wr, input logic mr, input logic mw,
                       input int kind, input logic e_sp, input logic e_busy, input logic e_wf);
        exp_t e, g;
        in_instr = ins; in_pc = pc; in_opa = ins ^ 32'hA5A5_0000; in_opb = ~ins;
        in_memdata = ins + 32'd7; in_rega = ins[25:21]; in_regb = ins[20:16];
        in_wreg = wr; in_regwrite = rw; in_memread = mr; in_memwrite = mw;
        in_ctrl = ins[5:0]; in_shamt = ins[10:6];
        in_serial = ser; in_notify = nt; fwd_stall = st; flush = fl;
        #1 chk({tag, ".wf"}, want_freeze, e_wf);
        e.instr   = (kind == K_BUB) ? 32'd0 : ins;
        e.pc      = (kind == K_BUB) ? exp_pc : pc;
        e.opa     = (kind == K_BUB) ? 32'd0 : ins ^ 32'hA5A5_0000;
        e.memdata = (kind == K_BUB) ? 32'd0 : ins + 32'd7;
        e.wreg    = (kind == K_BUB) ? 5'd0 : wr;
        e.ctrl    = (kind == K_BUB) ? 6'd0 : ins[5:0];
        e.rw      = (kind == K_PASS) && rw && (wr != 5'd0);
        e.mr      = (kind == K_PASS) && mr;
        e.mw      = (kind == K_PASS) && mw;
        e.sp      = e_sp;
        e.busy    = e_busy;
        exp_pc = e.pc;
        if (kind == K_BUB) m_bub++;
        if (kind == K_SER) m_ser++;
        q.push_back(e);
        @(posedge CLK);
        #1;
        g = q.pop_front();
        chk({tag, ".instr"}, out_instr, g.instr);
        chk({tag, ".pc"}, out_pc, g.pc);
        chk({tag, ".opa"}, out_opa, g.opa);
        chk({tag, ".memdata"}, out_memdata, g.memdata);
        chk({tag, ".wreg"}, out_wreg, g.wreg);
        chk({tag, ".ctrl"}, out_ctrl, g.ctrl);
        chk({tag, ".rw"}, out_regwrite, g.rw);
        chk({tag, ".mr"}, out_memread, g.mr);
        chk({tag, ".mw"}, out_memwrite, g.mw);
        chk({tag, ".sp"}, sys_pulse, g.sp);
        chk({tag, ".busy"}, busy, g.busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 RESET = 1'b0;
        #2 rst_chk("reset0");
        @(negedge CLK) RESET = 1'b1;
        cyc("add",    32'h00221820, 32'h100, 0,0,0,0, 1,5'd3, 0,0, K_PASS, 0,0,0);
        // syscall with notify
        cyc("sys",    32'h0000000C, 32'h104, 1,1,0,0, 0,5'd0, 0,0, K_SER,  0,1,1);
        cyc("sys_d1", 32'h01094020, 32'h108, 0,0,0,0, 1,5'd8, 0,0, K_BUB,  0,1,1);
        cyc("sys_d2", 32'h01094020, 32'h108, 0,0,0,0, 1,5'd8, 0,0, K_BUB,  0,1,1);
        cyc("sys_d3", 32'h01094020, 32'h108, 0,0,0,0, 1,5'd8, 0,0, K_BUB,  0,1,1);
        cyc("sys_nt", 32'h01094020, 32'h108, 0,0,0,0, 1,5'd8, 0,0, K_BUB,  1,0,0);
        cyc("sys_rs", 32'h01094020, 32'h108, 0,0,0,0, 1,5'd8, 0,0, K_PASS, 0,0,0);
        // SC: silent drain; in_serial held high into NOTIFY must not retrigger
        cyc("sc",     32'hE0A20000, 32'h10C, 1,0,0,0, 1,5'd2, 0,1, K_SER,  0,1,1);
        cyc("sc_d1",  32'hE0A20000, 32'h10C, 1,0,0,0, 1,5'd2, 0,1, K_BUB,  0,1,1);
        cyc("sc_d2",  32'hE0A20000, 32'h10C, 1,0,0,0, 1,5'd2, 0,1, K_BUB,  0,1,1);
        cyc("sc_d3",  32'hE0A20000, 32'h10C, 1,0,0,0, 1,5'd2, 0,1, K_BUB,  0,1,1);
        cyc("sc_nt",  32'hE0A20000, 32'h10C, 1,0,0,0, 1,5'd2, 0,1, K_BUB,  0,0,0);
        cyc("sc_rs",  32'h00431020, 32'h110, 0,0,0,0, 1,5'd2, 0,0, K_PASS, 0,0,0);
        // load-use stall
        cyc("lw",     32'h8C430000, 32'h114, 0,0,0,0, 1,5'd3, 1,0, K_PASS, 0,0,0);
        cyc("st1",    32'h00631020, 32'h118, 0,0,1,0, 1,5'd2, 0,0, K_BUB,  0,0,1);
        cyc("st2",    32'h00631020, 32'h118, 0,0,1,0, 1,5'd2, 0,0, K_BUB,  0,0,1);
        cyc("use",    32'h00631020, 32'h118, 0,0,0,0, 1,5'd2, 0,0, K_PASS, 0,0,0);
        cyc("wreg0",  32'h00000820, 32'h11C, 0,0,0,0, 1,5'd0, 0,0, K_PASS, 0,0,0);
        // flush priority in IDLE
        cyc("fl_st",  32'h00221820, 32'h120, 0,0,1,1, 1,5'd3, 0,0, K_BUB,  0,0,1);
        cyc("fl_ser", 32'h0000000C, 32'h120, 1,1,0,1, 0,5'd0, 0,0, K_BUB,  0,0,1);
        cyc("fl",     32'h00221820, 32'h120, 0,0,0,1, 1,5'd3, 0,0, K_BUB,  0,0,0);
        // flush in DRAIN cycle 2 cancels the notify
        cyc("fsys",   32'h0000000C, 32'h124, 1,1,0,0, 0,5'd0, 0,0, K_SER,  0,1,1);
        cyc("fsys_d1",32'h00221820, 32'h128, 0,0,0,0, 1,5'd3, 0,0, K_BUB,  0,1,1);
        cyc("fsys_d2",32'h00221820, 32'h128, 0,0,0,1, 1,5'd3, 0,0, K_BUB,  0,0,1);
        cyc("fsys_p1",32'h00221820, 32'h128, 0,0,0,0, 1,5'd3, 0,0, K_PASS, 0,0,0);
        cyc("fsys_p2",32'h01094020, 32'h12C, 0,0,0,0, 1,5'd8, 0,0, K_PASS, 0,0,0);
        // fwd_stall ignored while draining, masked from want_freeze in NOTIFY
        cyc("ssys",   32'h0000000C, 32'h130, 1,1,0,0, 0,5'd0, 0,0, K_SER,  0,1,1);
        cyc("ssys_d1",32'h00221820, 32'h134, 0,0,1,0, 1,5'd3, 0,0, K_BUB,  0,1,1);
        cyc("ssys_d2",32'h00221820, 32'h134, 0,0,1,0, 1,5'd3, 0,0, K_BUB,  0,1,1);
        cyc("ssys_d3",32'h00221820, 32'h134, 0,0,1,0, 1,5'd3, 0,0, K_BUB,  0,1,1);
        cyc("ssys_nt",32'h00221820, 32'h134, 0,0,1,0, 1,5'd3, 0,0, K_BUB,  1,0,0);
        cyc("ssys_rs",32'h00221820, 32'h134, 0,0,0,0, 1,5'd3, 0,0, K_PASS, 0,0,0);
`ifdef ID_ISSUE_PERFCNT_EN
        chk("perf_bub", perf_bubbles, m_bub);
        chk("perf_ser", {16'd0, perf_serial}, m_ser);
`endif
        // asynchronous reset mid-drain
        cyc("rsys",   32'h0000000C, 32'h140, 1,1,0,0, 0,5'd0, 0,0, K_SER,  0,1,1);
        cyc("rsys_d1",32'h00221820, 32'h144, 0,0,0,0, 1,5'd3, 0,0, K_BUB,  0,1,1);
        #2 RESET = 1'b0;
        #1 rst_chk("reset1");
`ifdef ID_ISSUE_PERFCNT_EN
        chk("perf_bub_rst", perf_bubbles, 32'd0);
        chk("perf_ser_rst", {16'd0, perf_serial}, 32'd0);
`endif
        exp_pc = '0; m_bub = 0; m_ser = 0;
        @(negedge CLK) RESET = 1'b1;
        cyc("post1",  32'h00221820, 32'h148, 0,0,0,0, 1,5'd3, 0,0, K_PASS, 0,0,0);
        cyc("post2",  32'h01094020, 32'h14C, 0,0,0,0, 1,5'd8, 0,0, K_PASS, 0,0,0);
        cyc("post3",  32'h00431020, 32'h150, 0,0,0,0, 1,5'd2, 0,0, K_PASS, 0,0,0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
